// File: rtl/mem_rd_responder.sv
// Masked-write memory with a valid/ready read port, 1-cycle in-flight stage and 2-entry response FIFO.
// Define MEM_RD_RESPONDER_BYPASS_EN to forward a same-cycle same-address write into the read.
module mem_rd_responder #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int WORDS = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] wr_mask,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [AW-1:0] rd_req_addr,
    output logic          rd_resp_valid,
    input  logic          rd_resp_ready,
    output logic [DW-1:0] rd_resp_data,
    output logic          rd_resp_err
);

    localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

    logic [DW-1:0] mem [WORDS];

    logic [1:0]    occ;
    logic [1:0]    fifo_cnt;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_err;

    logic          if_valid;
    logic          if_err;
    logic [DW-1:0] if_data;

    logic          wr_hit;
    logic          rd_hit;
    logic          accept;
    logic          pop;
    logic          pop_fifo;
    logic          push;
    logic          head_valid;
    logic [DW-1:0] head_data;
    logic          head_err;
    logic [DW-1:0] rd_word;

    assign wr_hit = wr_en && ({1'b0, wr_addr} < WORDS_L);
    assign rd_hit = {1'b0, rd_req_addr} < WORDS_L;

    assign rd_req_ready = (occ < 2'd2) && !rst;
    assign accept       = rd_req_valid && rd_req_ready;

    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
            rd_word = mem[rd_req_addr];
`ifdef MEM_RD_RESPONDER_BYPASS_EN
            if (wr_hit && (wr_addr == rd_req_addr))
                rd_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit)
            mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end

    // With the FIFO empty the in-flight word is the head, giving 1-cycle latency.
    assign head_valid = (fifo_cnt != 2'd0) || if_valid;
    assign head_data  = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr] : if_data;
    assign head_err   = (fifo_cnt != 2'd0) ? fifo_err[rd_ptr] : if_err;

    assign rd_resp_valid = head_valid && !rst;
    assign rd_resp_data  = rd_resp_valid ? head_data : '0;
    assign rd_resp_err   = rd_resp_valid && head_err;

    assign pop      = rd_resp_valid && rd_resp_ready;
    assign pop_fifo = pop && (fifo_cnt != 2'd0);
    assign push     = if_valid && !(pop && (fifo_cnt == 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            if_valid <= 1'b0;
        end else begin
            occ      <= occ + 2'(accept) - 2'(pop);
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop_fifo);
            if_valid <= accept;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop_fifo)
                rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if_data <= rd_word;
            if_err  <= !rd_hit;
        end
        if (push) begin
            fifo_data[wr_ptr] <= if_data;
            fifo_err[wr_ptr]  <= if_err;
        end
    end

endmodule
